// File: rtl/muldiv_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Multi-cycle unsigned multiply/divide controller. Implements MUL, MULHU,
// DIVU and REMU by driving the shared 32-bit combinational ALU for 32
// iterations. The ALU does every add/subtract; this block owns the operand
// shift registers, carry/borrow recovery, iteration counting and the
// start/done handshake. The core stalls on oBusy while this block owns the ALU.
//
// Ports:
//   iCLK, iRSTn      clock (rising edge), asynchronous active-low reset
//   iStart           request, sampled only in IDLE or DONE
//   iOp[1:0]         00 MUL, 01 MULHU, 10 DIVU, 11 REMU
//   iA, iB           multiplicand/dividend, multiplier/divisor
//   oBusy            high while iterating (RUN)
//   oDone            one-cycle pulse in DONE
//   oResult          result, registered on entry to DONE and held afterwards
//   oIllegal         set when a divide is requested with divide compiled out
//   oAluControl      ALU operation select (ALU_ADD / ALU_SUB codes)
//   oAluA, oAluB     ALU operands
//   iAluResult       ALU result, read in the same cycle the operands are driven
//
// Build option: define MULDIV_DIV_EN to include the restoring divider.
// Without it, ops 10/11 go straight to DONE with all-ones and oIllegal set.
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             iCLK,
    input  logic             iRSTn,
    input  logic             iStart,
    input  logic [1:0]       iOp,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIDTH-1:0] oResult,
    output logic             oIllegal,
    output logic [3:0]       oAluControl,
    output logic [WIDTH-1:0] oAluA,
    output logic [WIDTH-1:0] oAluB,
    input  logic [WIDTH-1:0] iAluResult
);

    // ALU operation codes, matching the ALU's iControl encoding
    localparam logic [3:0] ALU_ADD = 4'b0010;
`ifdef MULDIV_DIV_EN
    localparam logic [3:0] ALU_SUB = 4'b0110;
`endif

    localparam int         MSB       = WIDTH - 1;
    localparam logic [5:0] LAST_ITER = 6'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } stateT;

    stateT        state_q, state_d;
    logic [5:0]   count_q, count_d;
    logic         selHi_q, selHi_d;
`ifdef MULDIV_DIV_EN
    logic         isDiv_q, isDiv_d;
    logic         borrow;
`endif
    // acc: multiply high word / divide partial remainder
    // shift: multiply low word (multiplier) / divide quotient (dividend)
    // operand: multiplicand / divisor
    logic [MSB:0] acc_q, acc_d;
    logic [MSB:0] shift_q, shift_d;
    logic [MSB:0] operand_q, operand_d;
    logic [MSB:0] result_q, result_d;
    logic         illegal_q, illegal_d;

    logic         launch;
    logic         carry;
    logic [3:0]   aluControl;
    logic [MSB:0] aluA, aluB;

    // State and datapath registers; reset aborts any operation immediately
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q   <= IDLE;
            count_q   <= '0;
            selHi_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
            isDiv_q   <= 1'b0;
`endif
            acc_q     <= '0;
            shift_q   <= '0;
            operand_q <= '0;
            result_q  <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            selHi_q   <= selHi_d;
`ifdef MULDIV_DIV_EN
            isDiv_q   <= isDiv_d;
`endif
            acc_q     <= acc_d;
            shift_q   <= shift_d;
            operand_q <= operand_d;
            result_q  <= result_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state, iteration datapath and ALU drive. Outside RUN the ALU sees
    // ADD with zero operands. Carry/borrow are recovered from the ALU's
    // operand and result MSBs since the ALU exposes only a 32-bit result.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        selHi_d    = selHi_q;
`ifdef MULDIV_DIV_EN
        isDiv_d    = isDiv_q;
        borrow     = 1'b0;
`endif
        acc_d      = acc_q;
        shift_d    = shift_q;
        operand_d  = operand_q;
        result_d   = result_q;
        illegal_d  = illegal_q;
        launch     = 1'b0;
        carry      = 1'b0;
        aluControl = ALU_ADD;
        aluA       = '0;
        aluB       = '0;

        case (state_q)
            IDLE: launch = iStart;
            RUN: begin
`ifdef MULDIV_DIV_EN
                if (isDiv_q) begin
                    // Restoring divide: trial-subtract divisor from {r, next q bit}.
                    // r[MSB] set means the shifted value exceeds 32 bits, so it
                    // is certainly >= divisor even if the 32-bit subtract borrows.
                    aluControl = ALU_SUB;
                    aluA       = {acc_q[MSB-1:0], shift_q[MSB]};
                    aluB       = operand_q;
                    borrow     = (~aluA[MSB] & aluB[MSB]) |
                                 ((~aluA[MSB] | aluB[MSB]) & iAluResult[MSB]);
                    if (acc_q[MSB] || !borrow) begin
                        acc_d   = iAluResult;
                        shift_d = {shift_q[MSB-1:0], 1'b1};
                    end else begin
                        acc_d   = aluA;
                        shift_d = {shift_q[MSB-1:0], 1'b0};
                    end
                end else begin
`endif
                    // Shift-add multiply: add multiplicand when low bit is set,
                    // then shift {carry, sum, lo} right by one
                    aluControl = ALU_ADD;
                    aluA       = acc_q;
                    aluB       = shift_q[0] ? operand_q : '0;
                    carry      = (aluA[MSB] & aluB[MSB]) |
                                 ((aluA[MSB] | aluB[MSB]) & ~iAluResult[MSB]);
                    acc_d      = {carry, iAluResult[MSB:1]};
                    shift_d    = {iAluResult[0], shift_q[MSB:1]};
`ifdef MULDIV_DIV_EN
                end
`endif
                if (count_q == '0) begin
                    state_d  = DONE;
                    result_d = selHi_q ? acc_d : shift_d;
                end else begin
                    count_d = count_q - 6'd1;
                end
            end
            DONE: begin
                if (iStart) begin
                    launch = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Accepting a request loads operands and restarts the counter
        if (launch) begin
            state_d   = RUN;
            count_d   = LAST_ITER;
            selHi_d   = iOp[0];
            illegal_d = 1'b0;
            acc_d     = '0;
`ifdef MULDIV_DIV_EN
            isDiv_d   = iOp[1];
            shift_d   = iOp[1] ? iA : iB;
            operand_d = iOp[1] ? iB : iA;
`else
            shift_d   = iB;
            operand_d = iA;
            if (iOp[1]) begin
                state_d   = DONE;
                result_d  = '1;
                illegal_d = 1'b1;
            end
`endif
        end
    end

    assign oBusy       = (state_q == RUN);
    assign oDone       = (state_q == DONE);
    assign oResult     = result_q;
    assign oIllegal    = illegal_q;
    assign oAluControl = aluControl;
    assign oAluA       = aluA;
    assign oAluB       = aluB;

endmodule
